tdpram_port_arbiter: RTL

Shares the 64x8 true-dual-port RAM between NREQ independent requesters. Each cycle it grants up to two requests, one per RAM port, with round-robin fairness, and holds back any pair that would collide on the same address. It returns read data to the owning requester and sequences the RAM's clear and optional initialisation after reset. It sits directly between the requester fabric and the RAM's A/B port pins.

---
 rtl/tdpram_port_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tdpram_port_arbiter.sv
// tdpram_port_arbiter: shares one 64x8 true-dual-port RAM between NREQ
// requesters. Grants up to two requests per cycle (port A, then port B) in
// round-robin order, withholds port B on same-address hazards, and routes
// read data back to the owning requester after the RAM read latency.
// After reset the RAM is cleared; the optional post-clear zero sweep is
// compiled in with the macro TDPRAM_ARB_INIT_EN.
module tdpram_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*DW-1:0]   rsp_rdata,
    output logic                 ram_sclr,
    output logic                 ram_we_a,
    output logic                 ram_we_b,
    output logic [AW-1:0]        ram_addr_a,
    output logic [AW-1:0]        ram_addr_b,
    output logic [DW-1:0]        ram_din_a,
    output logic [DW-1:0]        ram_din_b,
    input  logic [DW-1:0]        ram_dout_a,
    input  logic [DW-1:0]        ram_dout_b
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
`ifdef TDPRAM_ARB_INIT_EN
    localparam logic [1:0] ST_AFTER_CLR = ST_INIT;
`else
    localparam logic [1:0] ST_AFTER_CLR = ST_RUN;
`endif

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic          init_last;

    logic          gnt_a;
    logic          gnt_b;
    logic          cand_b;
    logic [IW-1:0] id_a;
    logic [IW-1:0] id_b;
    logic [AW-1:0] addr_a_sel;
    logic [AW-1:0] addr_b_sel;
    logic          we_a_sel;
    logic          we_b_sel;

    // Read-return pipeline: one {valid, id} entry per RAM latency cycle.
    logic [RD_LAT-1:0] rd_vld_a;
    logic [RD_LAT-1:0] rd_vld_b;
    logic [IW-1:0]     rd_id_a [RD_LAT];
    logic [IW-1:0]     rd_id_b [RD_LAT];

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
    endfunction

`ifdef TDPRAM_ARB_INIT_EN
    logic [AW-2:0] init_cnt;

    // Sweep counter: one even/odd address pair per INIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign init_last = &init_cnt;
`else
    assign init_last = 1'b1;
`endif

    // Sequencer: one clear cycle, optional sweep, then normal arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLR;
        end else begin
            case (state)
                ST_CLR:  state <= ST_AFTER_CLR;
                ST_INIT: if (init_last) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    // The clear pulse is held off while reset is asserted so it appears only
    // in the first cycle after release.
    assign ram_sclr = rst_n && (state == ST_CLR);

    // Round-robin scan from ptr: first valid requester -> A, next -> B candidate.
    always_comb begin
        logic [IW-1:0] cur;
        cur    = '0;
        gnt_a  = 1'b0;
        cand_b = 1'b0;
        id_a   = '0;
        id_b   = '0;
        if (state == ST_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                cur = IW'((int'(ptr) + k) % NREQ);
                if (req_valid[cur]) begin
                    if (!gnt_a) begin
                        gnt_a = 1'b1;
                        id_a  = cur;
                    end else if (!cand_b) begin
                        cand_b = 1'b1;
                        id_b   = cur;
                    end
                end
            end
        end
    end

    assign addr_a_sel = req_addr[id_a*AW +: AW];
    assign addr_b_sel = req_addr[id_b*AW +: AW];
    assign we_a_sel   = req_we[id_a];
    assign we_b_sel   = req_we[id_b];

    // Same-address pairs involving a write are never issued together; B idles
    // and its requester wins port A next cycle because ptr moves past A.
    assign gnt_b = cand_b && !((addr_b_sel == addr_a_sel) && (we_a_sel || we_b_sel));

    // Ready is the one-hot OR of the two port grants.
    always_comb begin
        req_ready = '0;
        if (gnt_a) req_ready[id_a] = 1'b1;
        if (gnt_b) req_ready[id_b] = 1'b1;
    end

    // RAM pins: sweep pattern during INIT, granted request in RUN, else idle zeros.
    always_comb begin
        ram_we_a   = 1'b0;
        ram_we_b   = 1'b0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_din_a  = '0;
        ram_din_b  = '0;
`ifdef TDPRAM_ARB_INIT_EN
        if (state == ST_INIT) begin
            ram_we_a   = 1'b1;
            ram_we_b   = 1'b1;
            ram_addr_a = {init_cnt, 1'b0};
            ram_addr_b = {init_cnt, 1'b1};
        end
`endif
        if (gnt_a) begin
            ram_we_a   = we_a_sel;
            ram_addr_a = addr_a_sel;
            ram_din_a  = req_wdata[id_a*DW +: DW];
        end
        if (gnt_b) begin
            ram_we_b   = we_b_sel;
            ram_addr_b = addr_b_sel;
            ram_din_b  = req_wdata[id_b*DW +: DW];
        end
    end

    // Fairness pointer moves just past the last requester granted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_b) begin
            ptr <= next_id(id_b);
        end else if (gnt_a) begin
            ptr <= next_id(id_a);
        end
    end

    // Track accepted reads through the RAM latency so data returns to its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_a <= '0;
            rd_vld_b <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                rd_id_a[k] <= '0;
                rd_id_b[k] <= '0;
            end
        end else begin
            rd_vld_a[0] <= gnt_a && !we_a_sel;
            rd_vld_b[0] <= gnt_b && !we_b_sel;
            rd_id_a[0]  <= id_a;
            rd_id_b[0]  <= id_b;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_a[k] <= rd_vld_a[k-1];
                rd_vld_b[k] <= rd_vld_b[k-1];
                rd_id_a[k]  <= rd_id_a[k-1];
                rd_id_b[k]  <= rd_id_b[k-1];
            end
        end
    end

    // Capture matured RAM data into the owner's response slot and pulse valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (rd_vld_a[RD_LAT-1]) begin
                rsp_valid[rd_id_a[RD_LAT-1]]              <= 1'b1;
                rsp_rdata[rd_id_a[RD_LAT-1]*DW +: DW]     <= ram_dout_a;
            end
            if (rd_vld_b[RD_LAT-1]) begin
                rsp_valid[rd_id_b[RD_LAT-1]]              <= 1'b1;
                rsp_rdata[rd_id_b[RD_LAT-1]*DW +: DW]     <= ram_dout_b;
            end
        end
    end

endmodule
